// File: rtl/vec_mem_ctrl_if.sv
// ============================================================================
//  Module   : vec_mem_ctrl_if
//  Purpose  : Core request/response and memory-side bus of vec_mem_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface vec_mem_ctrl_if;
   logic         req;
   logic         we;
   logic [15:0]  addr;
   logic [3:0]   len;
   logic [255:0] wvec;
   logic         ready;
   logic         done;
   logic         ovf;
   logic         rvalid;
   logic [15:0]  rdata;
   logic [255:0] rvec;
   logic [15:0]  mem_addr;
   logic         mem_rd;
   logic         mem_wr;
   logic [15:0]  mem_wdata;
   logic [15:0]  mem_rdata;

   modport slave (
      input  req, we, addr, len, wvec, mem_rdata,
      output ready, done, ovf, rvalid, rdata, rvec,
             mem_addr, mem_rd, mem_wr, mem_wdata
   );

   modport master (
      output req, we, addr, len, wvec, mem_rdata,
      input  ready, done, ovf, rvalid, rdata, rvec,
             mem_addr, mem_rd, mem_wr, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/vec_mem_ctrl.sv
// ============================================================================
//  Module   : vec_mem_ctrl
//  Purpose  : Scalar/vector burst memory controller with fixed-latency reads.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_mem_ctrl #(
   parameter int MEM_LAT = 2
) (
   input  wire logic     Clk1,
   input  wire logic     Reset,
   vec_mem_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_RD_DRAIN = 3'd2,
      S_WR       = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_state_next;

   logic [15:0]    r_addr;
   logic [3:0]     r_len;
   logic [255:0]   r_wvec;
   logic [3:0]     r_beat;
   logic [3:0]     r_ret;
   logic           r_ovf_acc;
   logic [MEM_LAT-1:0] r_tok;

   logic           r_done;
   logic           r_ovf;
   logic           r_rvalid;
   logic [15:0]    r_rdata;
   logic [255:0]   r_rvec;
   logic [15:0]    r_mem_addr;
   logic           r_mem_rd;
   logic           r_mem_wr;
   logic [15:0]    r_mem_wdata;

   logic           w_accept;
   logic           w_ret;
   logic           w_ret_last;
   logic           w_last_beat;
   logic           w_wrap;
   logic [3:0]     w_beat_inc;
   logic [15:0]    w_next_addr;
   logic [15:0]    w_wword;

   logic [3:0]     w_beat_next;
   logic           w_ovf_acc_next;
   logic           w_mem_rd_next;
   logic           w_mem_wr_next;
   logic [15:0]    w_mem_addr_next;
   logic [15:0]    w_mem_wdata_next;
   logic           w_done_next;
   logic           w_ovf_next;

   assign w_accept    = bus.req && (r_state == S_IDLE);
   assign w_ret       = r_tok[MEM_LAT-1];
   assign w_ret_last  = w_ret && (r_ret == r_len);
   assign w_last_beat = (r_beat == r_len);
   assign w_beat_inc  = r_beat + 4'd1;
   assign w_next_addr = r_addr + {12'd0, w_beat_inc};
   assign w_wword     = r_wvec[{w_beat_inc, 4'b0000} +: 16];
   // Current beat address passed 0xFFFF iff addr + beat overflows 16 bits.
   assign w_wrap      = (r_addr > (16'hFFFF - {12'd0, r_beat}));

   always_comb begin
      w_state_next     = r_state;
      w_beat_next      = r_beat;
      w_ovf_acc_next   = r_ovf_acc;
      w_mem_rd_next    = 1'b0;
      w_mem_wr_next    = 1'b0;
      w_mem_addr_next  = r_mem_addr;
      w_mem_wdata_next = r_mem_wdata;
      w_done_next      = 1'b0;
      w_ovf_next       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_beat_next     = 4'd0;
               w_ovf_acc_next  = 1'b0;
               w_mem_addr_next = bus.addr;
               if (bus.we) begin
                  w_state_next     = S_WR;
                  w_mem_wr_next    = 1'b1;
                  w_mem_wdata_next = bus.wvec[15:0];
               end else begin
                  w_state_next  = S_RD_ISSUE;
                  w_mem_rd_next = 1'b1;
               end
            end
         end
         S_RD_ISSUE: begin
            w_ovf_acc_next = r_ovf_acc | w_wrap;
            if (w_last_beat) begin
               w_state_next = S_RD_DRAIN;
            end else begin
               w_beat_next     = w_beat_inc;
               w_mem_rd_next   = 1'b1;
               w_mem_addr_next = w_next_addr;
            end
         end
         S_RD_DRAIN: begin
            if (w_ret_last) begin
               w_state_next = S_DONE;
               w_done_next  = 1'b1;
               w_ovf_next   = r_ovf_acc;
            end
         end
         S_WR: begin
            w_ovf_acc_next = r_ovf_acc | w_wrap;
            if (w_last_beat) begin
               w_state_next = S_DONE;
               w_done_next  = 1'b1;
               w_ovf_next   = r_ovf_acc | w_wrap;
            end else begin
               w_beat_next      = w_beat_inc;
               w_mem_wr_next    = 1'b1;
               w_mem_addr_next  = w_next_addr;
               w_mem_wdata_next = w_wword;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk1 or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge Clk1 or posedge Reset) begin
      if (Reset) begin
         r_addr      <= 16'd0;
         r_len       <= 4'd0;
         r_wvec      <= '0;
         r_beat      <= 4'd0;
         r_ovf_acc   <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= 16'd0;
         r_mem_wdata <= 16'd0;
         r_done      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= bus.addr;
            r_len  <= bus.len;
            if (bus.we) begin
               r_wvec <= bus.wvec;
            end
         end
         r_beat      <= w_beat_next;
         r_ovf_acc   <= w_ovf_acc_next;
         r_mem_rd    <= w_mem_rd_next;
         r_mem_wr    <= w_mem_wr_next;
         r_mem_addr  <= w_mem_addr_next;
         r_mem_wdata <= w_mem_wdata_next;
         r_done      <= w_done_next;
         r_ovf       <= w_ovf_next;
      end
   end

   // Token pipeline mirrors the memory latency; its tail marks valid mem_rdata.
   always_ff @(posedge Clk1 or posedge Reset) begin
      if (Reset) begin
         r_tok    <= '0;
         r_ret    <= 4'd0;
         r_rvalid <= 1'b0;
         r_rdata  <= 16'd0;
         r_rvec   <= '0;
      end else begin
         r_tok[0] <= r_mem_rd;
         for (int k = 1; k < MEM_LAT; k++) begin
            r_tok[k] <= r_tok[k-1];
         end
         r_rvalid <= w_ret;
         if (w_accept) begin
            r_ret  <= 4'd0;
            r_rvec <= '0;
         end else if (w_ret) begin
            r_ret                            <= r_ret + 4'd1;
            r_rdata                          <= bus.mem_rdata;
            r_rvec[{r_ret, 4'b0000} +: 16]   <= bus.mem_rdata;
         end
      end
   end

   assign bus.ready     = (r_state == S_IDLE);
   assign bus.done      = r_done;
   assign bus.ovf       = r_ovf;
   assign bus.rvalid    = r_rvalid;
   assign bus.rdata     = r_rdata;
   assign bus.rvec      = r_rvec;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_rd    = r_mem_rd;
   assign bus.mem_wr    = r_mem_wr;
   assign bus.mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_vec_mem_ctrl.sv
// ============================================================================
//  Module   : tb_vec_mem_ctrl
//  Purpose  : Directed self-checking bench for vec_mem_ctrl (MEM_LAT = 2).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vec_mem_ctrl;

   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   vec_mem_ctrl_if bus ();

   vec_mem_ctrl #(.MEM_LAT(LAT)) dut (
      .Clk1  (clk),
      .Reset (rst),
      .bus   (bus)
   );

   function automatic logic [15:0] memfn(input logic [15:0] a);
      return (a == 16'h0040) ? 16'hBEEF : {8'h00, a[7:0]};
   endfunction

   // Fixed-latency memory: data for a read cycle appears LAT cycles later.
   logic [15:0] r_pipe [LAT];
   always @(posedge clk) begin
      r_pipe[0] <= bus.mem_rd ? memfn(bus.mem_addr) : 16'hDEAD;
      for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
   end
   assign bus.mem_rdata = r_pipe[LAT-1];

   // Presents a request in cycle 0; returns at the negedge of cycle 1.
   task automatic issue(input logic w, input logic [15:0] a, input logic [3:0] l,
                        input logic [255:0] wv);
      @(negedge clk);
      bus.req = 1'b1; bus.we = w; bus.addr = a; bus.len = l; bus.wvec = wv;
      checks++;
      if (bus.ready !== 1'b1) begin
         errors++; $display("FAIL accept_ready got %b exp 1", bus.ready);
      end
      @(negedge clk);
      bus.req = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.ready, bus.done, bus.ovf, bus.rvalid, bus.mem_rd, bus.mem_wr} !== 6'b100000) begin
         errors++; $display("FAIL reset_ctl got %b exp 100000",
            {bus.ready, bus.done, bus.ovf, bus.rvalid, bus.mem_rd, bus.mem_wr});
      end
      checks++;
      if ({bus.rdata, bus.mem_addr, bus.mem_wdata} !== 48'd0 || bus.rvec !== 256'd0) begin
         errors++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h exp 0",
            bus.rdata, bus.mem_addr, bus.mem_wdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      logic [3:0] exp;
      issue(1'b0, 16'h0040, 4'd0, '0);
      for (int c = 1; c <= 5; c++) begin
         exp = {c == 1, 1'b0, c == 4, c == 4};
         checks++;
         if ({bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done} !== exp) begin
            errors++; $display("FAIL single_ctl c=%0d got %b exp %b", c,
               {bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done}, exp);
         end
         if (c == 1) begin
            checks++;
            if (bus.mem_addr !== 16'h0040) begin
               errors++; $display("FAIL single_addr got %h exp 0040", bus.mem_addr);
            end
         end
         if (c == 4) begin
            checks++;
            if (bus.rdata !== 16'hBEEF || bus.ovf !== 1'b0) begin
               errors++; $display("FAIL single_data got rdata=%h ovf=%b exp BEEF 0", bus.rdata, bus.ovf);
            end
            checks++;
            if (bus.rvec !== {240'd0, 16'hBEEF}) begin
               errors++; $display("FAIL single_rvec got %h exp BEEF in word 0 only", bus.rvec);
            end
         end
         if (c == 5) begin
            checks++;
            if (bus.ready !== 1'b1) begin
               errors++; $display("FAIL single_ready got %b exp 1", bus.ready);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_burst_read();
      logic [3:0]   exp;
      logic [255:0] ev;
      for (int i = 0; i < 16; i++) ev[16*i +: 16] = 16'(i);
      issue(1'b0, 16'h1000, 4'd15, '0);
      for (int c = 1; c <= 20; c++) begin
         exp = {c <= 16, 1'b0, c >= 4 && c <= 19, c == 19};
         checks++;
         if ({bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done} !== exp) begin
            errors++; $display("FAIL burst_rd_ctl c=%0d got %b exp %b", c,
               {bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done}, exp);
         end
         if (c <= 16) begin
            checks++;
            if (bus.mem_addr !== 16'h1000 + 16'(c - 1)) begin
               errors++; $display("FAIL burst_rd_addr c=%0d got %h exp %h", c, bus.mem_addr,
                  16'h1000 + 16'(c - 1));
            end
         end
         if (c >= 4 && c <= 19) begin
            checks++;
            if (bus.rdata !== 16'(c - 4)) begin
               errors++; $display("FAIL burst_rd_data c=%0d got %h exp %h", c, bus.rdata, 16'(c - 4));
            end
         end
         if (c == 19) begin
            checks++;
            if (bus.rvec !== ev || bus.ovf !== 1'b0) begin
               errors++; $display("FAIL burst_rd_rvec got %h ovf=%b exp %h ovf=0", bus.rvec, bus.ovf, ev);
            end
         end
         if (c == 20) begin
            checks++;
            if (bus.ready !== 1'b1) begin
               errors++; $display("FAIL burst_rd_ready got %b exp 1", bus.ready);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_burst_write();
      logic [3:0]   exp;
      logic [255:0] wv;
      for (int i = 0; i < 16; i++) wv[16*i +: 16] = 16'hA000 + 16'(i);
      issue(1'b1, 16'h2000, 4'd15, wv);
      for (int c = 1; c <= 18; c++) begin
         exp = {1'b0, c <= 16, 1'b0, c == 17};
         checks++;
         if ({bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done} !== exp) begin
            errors++; $display("FAIL burst_wr_ctl c=%0d got %b exp %b", c,
               {bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done}, exp);
         end
         if (c <= 16) begin
            checks++;
            if ({bus.mem_addr, bus.mem_wdata} !== {16'h2000 + 16'(c - 1), 16'hA000 + 16'(c - 1)}) begin
               errors++; $display("FAIL burst_wr_beat c=%0d got %h/%h exp %h/%h", c, bus.mem_addr,
                  bus.mem_wdata, 16'h2000 + 16'(c - 1), 16'hA000 + 16'(c - 1));
            end
         end
         if (c == 18) begin
            checks++;
            if (bus.ready !== 1'b1) begin
               errors++; $display("FAIL burst_wr_ready got %b exp 1", bus.ready);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap();
      logic [3:0]  exp;
      logic [15:0] a;
      for (int run = 0; run < 2; run++) begin
         a = (run == 0) ? 16'hFFFE : 16'hFFFC;
         issue(1'b0, a, 4'd3, '0);
         for (int c = 1; c <= 8; c++) begin
            exp = {c <= 4, 1'b0, c >= 4 && c <= 7, c == 7};
            checks++;
            if ({bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done} !== exp) begin
               errors++; $display("FAIL wrap_ctl run=%0d c=%0d got %b exp %b", run, c,
                  {bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done}, exp);
            end
            if (c <= 4) begin
               checks++;
               if (bus.mem_addr !== a + 16'(c - 1)) begin
                  errors++; $display("FAIL wrap_addr run=%0d c=%0d got %h exp %h", run, c,
                     bus.mem_addr, a + 16'(c - 1));
               end
            end
            if (c == 7) begin
               checks++;
               if (bus.ovf !== (run == 0)) begin
                  errors++; $display("FAIL wrap_ovf run=%0d got %b exp %b", run, bus.ovf, run == 0);
               end
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_busy();
      logic [3:0] exp;
      issue(1'b0, 16'h3000, 4'd3, '0);
      for (int c = 1; c <= 9; c++) begin
         if (c == 2) begin
            bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h5000; bus.len = 4'd0;
         end
         if (c == 4) bus.req = 1'b0;
         exp = {c <= 4, 1'b0, c >= 4 && c <= 7, c == 7};
         checks++;
         if ({bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done} !== exp) begin
            errors++; $display("FAIL busy_ctl c=%0d got %b exp %b", c,
               {bus.mem_rd, bus.mem_wr, bus.rvalid, bus.done}, exp);
         end
         if (c >= 4 && c <= 7) begin
            checks++;
            if (bus.rdata !== 16'(c - 4)) begin
               errors++; $display("FAIL busy_data c=%0d got %h exp %h", c, bus.rdata, 16'(c - 4));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      issue(1'b0, 16'h4000, 4'd15, '0);
      repeat (5) @(negedge clk);
      checks++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h4005) begin
         errors++; $display("FAIL rstmid_beat5 got rd=%b addr=%h exp 1 4005", bus.mem_rd, bus.mem_addr);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.ready, bus.done, bus.ovf, bus.rvalid, bus.mem_rd, bus.mem_wr} !== 6'b100000) begin
         errors++; $display("FAIL rstmid_ctl got %b exp 100000",
            {bus.ready, bus.done, bus.ovf, bus.rvalid, bus.mem_rd, bus.mem_wr});
      end
      checks++;
      if ({bus.rdata, bus.mem_addr, bus.mem_wdata} !== 48'd0 || bus.rvec !== 256'd0) begin
         errors++; $display("FAIL rstmid_data got rdata=%h addr=%h exp 0", bus.rdata, bus.mem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({bus.rvalid, bus.done} !== 2'b00) begin
            errors++; $display("FAIL rstmid_late c=%0d got rvalid=%b done=%b exp 0 0", c,
               bus.rvalid, bus.done);
         end
      end
      issue(1'b0, 16'h0040, 4'd0, '0);
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.rvalid, bus.done, bus.rdata} !== {2'b11, 16'hBEEF} || bus.rvec !== {240'd0, 16'hBEEF}) begin
         errors++; $display("FAIL rstmid_after got rvalid=%b done=%b rdata=%h exp 1 1 BEEF",
            bus.rvalid, bus.done, bus.rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp;
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h6000; bus.len = 4'd0;
      bus.wvec = {240'd0, 16'h1234};
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 5) bus.req = 1'b0;
         case (c % 3)
            1: exp = 3'b100;
            2: exp = 3'b010;
            default: exp = 3'b001;
         endcase
         checks++;
         if ({bus.mem_wr, bus.done, bus.ready} !== exp) begin
            errors++; $display("FAIL b2b_ctl c=%0d got %b exp %b", c,
               {bus.mem_wr, bus.done, bus.ready}, exp);
         end
         if (c == 4) begin
            checks++;
            if ({bus.mem_addr, bus.mem_wdata} !== {16'h6000, 16'h1234}) begin
               errors++; $display("FAIL b2b_beat got %h/%h exp 6000/1234", bus.mem_addr, bus.mem_wdata);
            end
         end
      end
   endtask

   initial begin
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'd0; bus.len = 4'd0; bus.wvec = '0;
      test_reset();
      test_single_read();
      test_burst_read();
      test_burst_write();
      test_wrap();
      test_busy();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/vec_mem_ctrl.md
# vec_mem_ctrl

Burst memory controller between the CVP14 core's load/store path and main memory. It accepts one request at a time for a single scalar word or a vector burst of 1–16 words. For each beat it issues one memory access per cycle at consecutive addresses. Read data is realigned from a fixed-latency memory into a 256-bit vector, and write vectors are serialized word by word. It replaces the core's per-cycle Addr/RD/WR/DataIn sequencing with a request/done handshake and flags 16-bit address wrap.

## Interface
Parameters:
- MEM_LAT, 2, memory read latency in cycles (legal 1..4)

Ports:
- Clk1  in  1  sole clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- req  in  1  request strobe, sampled when ready=1
- we  in  1  1 = write burst, 0 = read burst
- addr  in  16  base word address
- len  in  4  beat count minus 1 (0 → 1 word, 15 → 16 words)
- wvec  in  256  write data, word i at bits [16i+15:16i]
- ready  out  1  controller idle, can accept req
- done  out  1  one-cycle completion pulse
- ovf  out  1  address wrapped past 0xFFFF; valid with done
- rvalid  out  1  rdata holds a returned read beat
- rdata  out  16  read beat data, in address order
- rvec  out  256  assembled read vector; valid from done until next accept
- mem_addr  out  16  memory address
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid MEM_LAT cycles after its mem_rd cycle

## Operation
- FSM states: IDLE, RD_ISSUE, RD_DRAIN, WR, DONE.
- ready = (state == IDLE). This is the only accept condition.
- A req while not ready is ignored. There is no queueing.
- Accept (req & ready):
  - latch we, addr, len; latch wvec on writes
  - clear beat counter, ovf accumulator and rvec (all 256 bits zeroed)
- RD_ISSUE:
  - each cycle drive mem_rd=1, mem_addr = (addr+i) mod 2^16 for i = 0..len
  - push a valid token into a MEM_LAT-deep pipeline
  - after beat len, go to RD_DRAIN
- Return path:
  - when a token exits the pipeline, register mem_rdata into rdata, pulse rvalid, write rvec word j (j = return index)
  - RD_DRAIN waits until the final token has been captured, then goes to DONE
- WR:
  - each cycle drive mem_wr=1, mem_addr = addr+i, mem_wdata = wvec word i
  - after beat len, go to DONE
- DONE:
  - done=1 for one cycle, ovf=1 if any beat address wrapped (addr + len > 0xFFFF)
  - next state IDLE
- ovf behaviour: wrap is not an error. Addresses still wrap to 0x0000 and the burst completes.
- Unused rvec words (index > len) read as 0.
- mem_rd and mem_wr are never high together. Both are 0 outside RD_ISSUE/WR.
- Reset mid-operation (async):
  - state → IDLE; pipeline tokens, counters, rvec, rdata cleared
  - data returned by memory after reset is ignored

## Timing
- Reset values: ready=1 (state IDLE); done, ovf, rvalid, mem_rd, mem_wr = 0; rdata, rvec, mem_addr, mem_wdata = 0.
- All outputs are registered except ready, which is decoded from state.
- Let N = len+1, with accept on the edge ending cycle 0.
- Read timing:
  - mem_rd high in cycles 1..N
  - beat i data present on mem_rdata in cycle 1+i+MEM_LAT
  - rvalid/rdata for beat i in cycle 2+i+MEM_LAT
  - done asserts in the same cycle as the final rvalid (cycle N+MEM_LAT+1)
  - ready returns in cycle N+MEM_LAT+2
- Write timing: mem_wr high in cycles 1..N; done in cycle N+1; ready in cycle N+2.
- Throughput: one beat per cycle with no bubbles. The minimum gap between accepts is one ready cycle.
- A req held high through DONE is accepted on the first ready cycle.

## Test plan
- Reset, then single read, len=0, addr=0x0040, memory returns 0xBEEF, MEM_LAT=2:
  - mem_rd only in cycle 1
  - rvalid and done in cycle 4, rdata=0xBEEF
  - rvec = 0x…0000BEEF with upper 240 bits zero
  - ovf=0
- 16-word read, addr=0x1000, memory returns word = addr[7:0]:
  - rvalid on 16 consecutive cycles, data in order
  - rvec word i = i
  - done in cycle 19
- 16-word write, addr=0x2000, wvec word i = 0xA000+i:
  - mem_wr cycles 1..16
  - mem_addr 0x2000..0x200F, mem_wdata 0xA000..0xA00F
  - done in cycle 17
  - mem_rd never high
- Wrap: read len=3, addr=0xFFFE:
  - addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001
  - ovf=1 with done
  - rerun with addr=0xFFFC gives ovf=0
- Busy rejection: second req issued mid-burst with we=1:
  - no extra memory strobes
  - first burst completes unchanged
- Reset asserted mid-read after beat 5:
  - all outputs 0 immediately, ready=1
  - late mem_rdata causes no rvalid
  - a subsequent len=0 read completes normally
